// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: region map, FSM states.
// Region match helper is reused by mem_region_decode.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    REG_RAM32K,
    REG_TEXT8K,
    REG_BIOS4K,
    REG_NONE
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [19:0] RAM32K_BASE = 20'h00000;
  localparam logic [19:0] RAM32K_MASK = 20'hF8000;
  localparam logic [19:0] TEXT8K_BASE = 20'hB8000;
  localparam logic [19:0] TEXT8K_MASK = 20'hFE000;
  localparam logic [19:0] BIOS4K_BASE = 20'hFF000;
  localparam logic [19:0] BIOS4K_MASK = 20'hFF000;

  function automatic logic in_region(
    input logic [19:0] addr,
    input logic [19:0] base,
    input logic [19:0] mask
  );
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational 20-bit address to on-chip region decode.
// Ports: i_addr (byte address) -> o_region (region_t, REG_NONE if unmapped).
module mem_region_decode
  import mem_bus_arbiter_pkg::*;
(
  input  logic [19:0] i_addr,
  output region_t     o_region
);

  always_comb begin
    o_region = REG_NONE;
    unique case (1'b1)
      in_region(i_addr, RAM32K_BASE, RAM32K_MASK):
        o_region = REG_RAM32K;
      in_region(i_addr, TEXT8K_BASE, TEXT8K_MASK):
        o_region = REG_TEXT8K;
      in_region(i_addr, BIOS4K_BASE, BIOS4K_MASK):
        o_region = REG_BIOS4K;
      default:
        o_region = REG_NONE;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port (CPU/loader) round-robin arbiter onto the shared memory bus.
// Ports: pN_req/addr/wdata/we in, pN_ack/rdata out; mem_* and m*_we/q to RAMs.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT  = 2,
  parameter bit          BIOS_WP = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p0_req,
  input  logic [19:0] p0_addr,
  input  logic [7:0]  p0_wdata,
  input  logic        p0_we,
  output logic        p0_ack,
  output logic [7:0]  p0_rdata,
  input  logic        p1_req,
  input  logic [19:0] p1_addr,
  input  logic [7:0]  p1_wdata,
  input  logic        p1_we,
  output logic        p1_ack,
  output logic [7:0]  p1_rdata,
  input  logic        bios_lock,
  output logic [19:0] mem_address,
  output logic [7:0]  mem_data,
  output logic        m32k_we,
  output logic        m8k_we,
  output logic        m4k_we,
  input  logic [7:0]  m32k_q,
  input  logic [7:0]  m8k_q,
  input  logic [7:0]  m4k_q,
  output logic        busy,
  output logic        grant
);

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_grant;
  logic [19:0] r_addr;
  logic [7:0]  r_data;
  logic        r_we;
  region_t     r_region;
  logic        r_m32k_we;
  logic        r_m8k_we;
  logic        r_m4k_we;
  logic        r_p0_ack;
  logic        r_p1_ack;
  logic [7:0]  r_p0_rdata;
  logic [7:0]  r_p1_rdata;

  logic        w_any;
  logic        w_pick;
  logic [19:0] w_addr;
  logic [7:0]  w_wdata;
  logic        w_we;
  logic        w_wp;
  region_t     w_region;
  logic [7:0]  w_q;

  // Under contention the port that did not own the last
  // transaction wins; otherwise the lone requester wins.
  assign w_any   = p0_req | p1_req;
  assign w_pick  = (p0_req & p1_req) ? ~r_grant : p1_req;
  assign w_addr  = w_pick ? p1_addr  : p0_addr;
  assign w_wdata = w_pick ? p1_wdata : p0_wdata;
  assign w_we    = w_pick ? p1_we    : p0_we;

  mem_region_decode u_dec (
    .i_addr   (w_addr),
    .o_region (w_region)
  );

  assign w_wp = BIOS_WP && bios_lock
             && (w_region == REG_BIOS4K);

  always_comb begin
    w_q = 8'hFF;
    unique case (r_region)
      REG_RAM32K: w_q = m32k_q;
      REG_TEXT8K: w_q = m8k_q;
      REG_BIOS4K: w_q = m4k_q;
      default:    w_q = 8'hFF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_grant    <= 1'b1;
      r_addr     <= '0;
      r_data     <= '0;
      r_we       <= 1'b0;
      r_region   <= REG_NONE;
      r_m32k_we  <= 1'b0;
      r_m8k_we   <= 1'b0;
      r_m4k_we   <= 1'b0;
      r_p0_ack   <= 1'b0;
      r_p1_ack   <= 1'b0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      r_m32k_we <= 1'b0;
      r_m8k_we  <= 1'b0;
      r_m4k_we  <= 1'b0;
      r_p0_ack  <= 1'b0;
      r_p1_ack  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant   <= w_pick;
            r_addr    <= w_addr;
            r_data    <= w_wdata;
            r_we      <= w_we;
            r_region  <= w_region;
            // Strobes are registered here so they
            // are high for exactly the ACCESS cycle.
            r_m32k_we <= w_we
                      && (w_region == REG_RAM32K);
            r_m8k_we  <= w_we
                      && (w_region == REG_TEXT8K);
            r_m4k_we  <= w_we && !w_wp
                      && (w_region == REG_BIOS4K);
            r_state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_cnt   <= LAT_M1;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == 3'd0) begin
            if (!r_we) begin
              if (r_grant) r_p1_rdata <= w_q;
              else         r_p0_rdata <= w_q;
            end
            r_p0_ack <= ~r_grant;
            r_p1_ack <= r_grant;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_address = r_addr;
  assign mem_data    = r_data;
  assign m32k_we     = r_m32k_we;
  assign m8k_we      = r_m8k_we;
  assign m4k_we      = r_m4k_we;
  assign p0_ack      = r_p0_ack;
  assign p1_ack      = r_p1_ack;
  assign p0_rdata    = r_p0_rdata;
  assign p1_rdata    = r_p1_rdata;
  assign busy        = (r_state != ST_IDLE);
  assign grant       = r_grant;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter with memory models and a
// transaction-level reference model (address map, round robin, latency).
module tb_mem_bus_arbiter;

  localparam int LAT = 2;
  localparam bit WP  = 1'b1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req = 0, p0_we = 0;
  logic [19:0] p0_addr = 0;
  logic [7:0]  p0_wdata = 0;
  logic        p0_ack;
  logic [7:0]  p0_rdata;
  logic        p1_req = 0, p1_we = 0;
  logic [19:0] p1_addr = 0;
  logic [7:0]  p1_wdata = 0;
  logic        p1_ack;
  logic [7:0]  p1_rdata;
  logic        bios_lock = 0;
  logic [19:0] mem_address;
  logic [7:0]  mem_data;
  logic        m32k_we, m8k_we, m4k_we;
  logic [7:0]  m32k_q, m8k_q, m4k_q;
  logic        busy, grant;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.RD_LAT(LAT), .BIOS_WP(WP)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_we(p0_we),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_we(p1_we),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .bios_lock(bios_lock),
    .mem_address(mem_address), .mem_data(mem_data),
    .m32k_we(m32k_we), .m8k_we(m8k_we), .m4k_we(m4k_we),
    .m32k_q(m32k_q), .m8k_q(m8k_q), .m4k_q(m4k_q),
    .busy(busy), .grant(grant)
  );

  // Block-RAM models with one registered read stage.
  logic [7:0]  mem32 [0:32767];
  logic [7:0]  mem8  [0:8191];
  logic [7:0]  mem4  [0:4095];
  int          we_cnt = 0;
  int          ack_cnt = 0;
  int          last_blk = -1;
  logic [19:0] last_addr = 0;
  logic [7:0]  last_data = 0;

  always @(posedge clock) begin
    if (m32k_we) mem32[mem_address[14:0]] <= mem_data;
    if (m8k_we)  mem8[mem_address[12:0]]  <= mem_data;
    if (m4k_we)  mem4[mem_address[11:0]]  <= mem_data;
    if (m32k_we | m8k_we | m4k_we) begin
      we_cnt <= we_cnt + int'(m32k_we)
              + int'(m8k_we) + int'(m4k_we);
      last_addr <= mem_address;
      last_data <= mem_data;
      last_blk  <= m32k_we ? 0 : (m8k_we ? 1 : 2);
    end
    if (p0_ack | p1_ack) ack_cnt <= ack_cnt + 1;
    m32k_q <= mem32[mem_address[14:0]];
    m8k_q  <= mem8[mem_address[12:0]];
    m4k_q  <= mem4[mem_address[11:0]];
  end

  // Reference model.
  logic [7:0] gold [int];
  logic [7:0] exp_rd [2];
  bit         exp_last;
  int         n_tests = 0;
  int         n_fail = 0;

  function automatic logic [7:0] seed_byte(input int a);
    return 8'((a * 37) ^ (a >> 7) ^ 8'h5A);
  endfunction

  // 0 RAM, 1 TEXT, 2 BIOS, 3 unmapped
  function automatic int region_of(input logic [19:0] a);
    int v;
    v = int'(a);
    if (v < 32'h8000) return 0;
    if (v >= 32'hB8000 && v < 32'hBA000) return 1;
    if (v >= 32'hFF000) return 2;
    return 3;
  endfunction

  function automatic logic [7:0] gval(input logic [19:0] a);
    if (gold.exists(int'(a))) return gold[int'(a)];
    return seed_byte(int'(a));
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model_txn(input bit port,
                           input logic [19:0] a,
                           input logic [7:0] d,
                           input bit we, input bit lock,
                           output int ew, output int blk);
    int r;
    r = region_of(a);
    exp_last = port;
    ew = 0;
    blk = r;
    if (we) begin
      if (r != 3 && !(r == 2 && WP && lock)) begin
        gold[int'(a)] = d;
        ew = 1;
      end
    end else begin
      exp_rd[port] = (r == 3) ? 8'hFF : gval(a);
    end
  endtask

  task automatic set_port(input bit port,
                          input logic [19:0] a,
                          input logic [7:0] d,
                          input bit we, input bit req);
    if (!port) begin
      p0_addr = a; p0_wdata = d; p0_we = we; p0_req = req;
    end else begin
      p1_addr = a; p1_wdata = d; p1_we = we; p1_req = req;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    p0_req = 0;
    p1_req = 0;
    @(posedge clock); #1;
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 1);
    check("rst_acks", {p0_ack, p1_ack}, 0);
    check("rst_we", {m32k_we, m8k_we, m4k_we}, 0);
    check("rst_rdata", {p0_rdata, p1_rdata}, 0);
    check("rst_bus", {mem_address, mem_data}, 0);
    reset = 1'b0;
    exp_last = 1'b1;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
  endtask

  // Single-port transaction: ack in cycle N+2+LAT, i.e. visible
  // after the (LAT+1)th edge following the sampling edge N.
  task automatic txn(input bit port,
                     input logic [19:0] a,
                     input logic [7:0] d,
                     input bit we, input bit lock);
    int w0, cyc, ew, blk;
    bit got;
    w0 = we_cnt;
    model_txn(port, a, d, we, lock, ew, blk);
    bios_lock = lock;
    set_port(port, a, d, we, 1'b1);
    cyc = 0;
    got = 0;
    while (!got && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      if (cyc == 1) check("busy", busy, 1);
      got = port ? p1_ack : p0_ack;
    end
    set_port(port, a, d, we, 1'b0);
    check("ack_latency", cyc, LAT + 2);
    check("rdata", port ? p1_rdata : p0_rdata, exp_rd[port]);
    check("other_rdata", port ? p0_rdata : p1_rdata,
          exp_rd[!port]);
    check("grant", grant, port);
    check("we_count", we_cnt - w0, ew);
    if (ew == 1) begin
      check("we_addr", last_addr, a);
      check("we_data", last_data, d);
      check("we_blk", last_blk, blk);
    end
    @(posedge clock); #1;
    check("ack_pulse", {p0_ack, p1_ack}, 0);
    check("idle", busy, 0);
  endtask

  task automatic contend(input logic [19:0] a0,
                         input logic [7:0] d0, input bit we0,
                         input logic [19:0] a1,
                         input logic [7:0] d1, input bit we1,
                         input bit lock);
    int ew0, ew1, b0, b1, w0, cyc, t0, t1;
    bit first;
    first = !exp_last;
    w0 = we_cnt;
    if (!first) begin
      model_txn(0, a0, d0, we0, lock, ew0, b0);
      model_txn(1, a1, d1, we1, lock, ew1, b1);
    end else begin
      model_txn(1, a1, d1, we1, lock, ew1, b1);
      model_txn(0, a0, d0, we0, lock, ew0, b0);
    end
    bios_lock = lock;
    set_port(0, a0, d0, we0, 1'b1);
    set_port(1, a1, d1, we1, 1'b1);
    t0 = 0; t1 = 0; cyc = 0;
    while ((t0 == 0 || t1 == 0) && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
      if (p0_ack) begin
        t0 = cyc; p0_req = 0;
        check("c_rdata0", p0_rdata, exp_rd[0]);
      end
      if (p1_ack) begin
        t1 = cyc; p1_req = 0;
        check("c_rdata1", p1_rdata, exp_rd[1]);
      end
    end
    p0_req = 0;
    p1_req = 0;
    check("c_first", first ? t1 : t0, LAT + 2);
    check("c_second", first ? t0 : t1, 2 * LAT + 5);
    check("c_we", we_cnt - w0, ew0 + ew1);
    check("c_grant", grant, !first);
    @(posedge clock); #1;
  endtask

  function automatic logic [19:0] rand_addr();
    logic [19:0] off;
    logic [19:0] unm [4];
    unm[0] = 20'h08000; unm[1] = 20'hB7FFF;
    unm[2] = 20'hBA000; unm[3] = 20'hFEFFF;
    off = 20'($urandom_range(0, 15));
    case ($urandom_range(0, 3))
      0: return 20'h00000 + off;
      1: return 20'hB8000 + off;
      2: return 20'hFF000 + off;
      default: return unm[off[1:0]];
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, a0;
    int tk[$];
    int cyc;
    for (int i = 0; i < 32768; i++) mem32[i] = seed_byte(i);
    for (int i = 0; i < 8192; i++)
      mem8[i] = seed_byte(32'hB8000 + i);
    for (int i = 0; i < 4096; i++)
      mem4[i] = seed_byte(32'hFF000 + i);
    @(posedge clock); #1;
    do_reset();

    // CPU write then read back
    txn(0, 20'h00123, 8'h5A, 1, 0);
    txn(0, 20'h00123, 8'h00, 0, 0);

    // Contention right after reset: CPU first
    do_reset();
    contend(20'hB8000, 8'h00, 0, 20'hFF010, 8'h77, 1, 0);
    txn(0, 20'h00010, 8'h00, 0, 0);
    // Last owner CPU: loader wins now
    contend(20'hFF010, 8'h00, 0, 20'hB8001, 8'h44, 1, 0);

    // Write-protected BIOS write, then read back
    txn(1, 20'hFF000, 8'h33, 1, 1);
    txn(0, 20'hFF000, 8'h00, 0, 0);

    // Unmapped read and write
    txn(0, 20'hA0000, 8'h00, 0, 0);
    txn(0, 20'hA0000, 8'h12, 1, 0);

    // Map boundaries
    txn(1, 20'h07FFF, 8'hA1, 1, 0);
    txn(0, 20'h07FFF, 8'h00, 0, 0);
    txn(1, 20'hB9FFF, 8'hB2, 1, 0);
    txn(0, 20'hB9FFF, 8'h00, 0, 0);
    txn(1, 20'hFFFFF, 8'hC3, 1, 0);
    txn(1, 20'hFFFFF, 8'h00, 0, 0);
    txn(0, 20'h08000, 8'hD4, 1, 0);

    // Reset during WAIT of a CPU write
    begin
      int ew, blk;
      w0 = we_cnt;
      model_txn(0, 20'h00200, 8'hC3, 1, 0, ew, blk);
      bios_lock = 0;
      set_port(0, 20'h00200, 8'hC3, 1, 1);
      repeat (2) begin @(posedge clock); #1; end
      do_reset();
      a0 = ack_cnt;
      repeat (2 * LAT + 6) begin
        @(posedge clock); #1;
        check("rst_no_we", {m32k_we, m8k_we, m4k_we}, 0);
      end
      check("rst_no_ack", ack_cnt - a0, 0);
      check("rst_we_before", we_cnt - w0, ew);
      txn(0, 20'h00200, 8'h00, 0, 0);
    end

    // CPU holds req: back-to-back reads
    exp_rd[0] = gval(20'h00123);
    exp_last = 0;
    set_port(0, 20'h00123, 8'h00, 0, 1);
    cyc = 0;
    while (tk.size() < 4 && cyc < 80) begin
      @(posedge clock); #1;
      cyc++;
      if (p0_ack) tk.push_back(cyc);
    end
    p0_req = 0;
    check("held_count", tk.size(), 4);
    for (int i = 0; i < tk.size(); i++)
      check("held_ack_cycle", tk[i],
            (LAT + 2) + i * (LAT + 3));
    check("held_rdata", p0_rdata, exp_rd[0]);
    check("held_p1_rdata", p1_rdata, exp_rd[1]);
    @(posedge clock); #1;

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        contend(rand_addr(), 8'($urandom), 1'($urandom),
                rand_addr(), 8'($urandom), 1'($urandom),
                1'($urandom));
      else
        txn(1'($urandom), rand_addr(), 8'($urandom),
            1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
